reg_file: RTL and testbench
===========================

REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning data word width in bits.
REQ-002 The block SHALL have parameter REG_COUNT, default 32, meaning number of architectural registers.
REQ-003 The block SHALL have parameter ADDR_W, default 5, meaning register address width, equal to log2(REG_COUNT).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port rs_addr, input, ADDR_W bits: read port A address (ALU operand a).
REQ-007 The block SHALL have port rt_addr, input, ADDR_W bits: read port B address (ALU operand b).
REQ-008 The block SHALL have port rd_addr, input, ADDR_W bits: write address.
REQ-009 The block SHALL have port wr_data, input, WIDTH bits: write data.
REQ-010 The block SHALL have port reg_write, input, 1 bit: write enable.
REQ-011 The block SHALL have port rs_data, output, WIDTH bits: read port A data.
REQ-012 The block SHALL have port rt_data, output, WIDTH bits: read port B data.
REQ-013 The block SHALL have port ready, output, 1 bit, registered: high once the post-reset clear sequence is complete.

Function
REQ-014 Reads SHALL be combinational, with zero-cycle latency from address to data.
REQ-015 Register 0 SHALL always read as 0, and writes to address 0 SHALL be discarded.
REQ-016 In state READY, when reg_write=1 and rd_addr!=0, mem[rd_addr] SHALL take the value of wr_data at the rising edge.
REQ-017 Write-through bypass: in READY, when reg_write=1 and rd_addr==rs_addr!=0, rs_data SHALL equal wr_data in the same cycle; rt_data SHALL behave identically.
REQ-018 When both read ports address the same register, both ports SHALL return identical data, including the bypass case.
REQ-019 The state machine SHALL have exactly two states, CLEAR and READY, with a clear index idx of ADDR_W bits.
REQ-020 CLEAR, rising edge with reset=0: mem[idx] SHALL be set to 0 and idx SHALL increment.
REQ-021 CLEAR, idx==REG_COUNT-1: mem[idx] SHALL be set to 0, the state SHALL become READY, and ready SHALL go to 1 on that same edge.
REQ-022 Clear duration: exactly REG_COUNT-1 rising edges (31 at defaults) from the first edge with reset=0 to ready=1.
REQ-023 While in CLEAR, reg_write SHALL be ignored and rs_data and rt_data SHALL read 0, with the bypass disabled.
REQ-024 The idx counter SHALL NOT wrap: after the last register is cleared, idx SHALL be held, since it is unused in READY.
REQ-025 READY SHALL be held until reset; no other event SHALL leave READY.

Reset
REQ-026 On every rising edge with reset=1: the state SHALL be set to CLEAR, idx SHALL be set to 1, and ready SHALL be set to 0.
REQ-027 reset asserted mid-clear or in READY SHALL restart the full clear sequence from idx=1.
REQ-028 reset SHALL take priority over reg_write on the same edge; that write SHALL be dropped.
REQ-029 Register storage SHALL NOT be cleared by reset directly; clearing SHALL happen only through the CLEAR sequence.

Structure
REQ-030 WIDTH, REG_COUNT, ADDR_W and the CLEAR/READY state encoding SHALL be defined in shared package cpu_pkg, which the ALU and control also use.
REQ-031 Read-port logic (zero-register check, bypass compare, CLEAR gating) SHALL be implemented as sub-module reg_read_port, instantiated twice.
REQ-032 Storage SHALL be a single REG_COUNT x WIDTH array, and no reset SHALL be applied to the array itself.

Verification
REQ-033 The bench SHALL assert reset=1 for 2 cycles, release it, and count edges: ready=0 for 30 edges, ready=1 after edge 31, and all 32 registers read 0.
REQ-034 The bench SHALL write 0xDEADBEEF to r5 with reg_write=1, set rs_addr=5, and check rs_data=0xDEADBEEF in the same cycle (bypass) and on the next cycle from storage.
REQ-035 The bench SHALL write 0x12345678 to r0, then read rs_addr=0 and rt_addr=0: both SHALL be 0x00000000.
REQ-036 The bench SHALL write 0xA5A5A5A5 to r7 and 0x0000000F to r8, then set rs_addr=7 and rt_addr=8: rs_data=0xA5A5A5A5 and rt_data=0x0000000F, matching ALU operand a/b expectations.
REQ-037 The bench SHALL write r3=0x1, assert reset at clear edge 10, apply reg_write=1 with rd_addr=4 during CLEAR: ready SHALL stay 0 for another 31 edges, after which r3=0 and r4=0.
REQ-038 The bench SHALL apply reset=1 and reg_write=1 with rd_addr=9 and wr_data=0xFF on the same edge: after the clear sequence completes, r9 SHALL read 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared datapath widths and register-file state encoding
package cpu_pkg;

    localparam int WIDTH     = 32;
    localparam int REG_COUNT = 32;
    localparam int ADDR_W    = $clog2(REG_COUNT);

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

endpackage

// File: rtl/reg_read_port.sv
// rtl/reg_read_port.sv - one combinational read port with r0 forcing and write-through bypass
module reg_read_port #(
    parameter int WIDTH  = cpu_pkg::WIDTH,
    parameter int ADDR_W = cpu_pkg::ADDR_W
) (
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [WIDTH-1:0]  i_mem_data,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]  i_wr_data,
    input  logic              i_wr_en,
    input  logic              i_ready,
    output logic [WIDTH-1:0]  o_data
);

    logic w_is_zero;
    logic w_bypass;

    assign w_is_zero = (i_addr == '0);
    assign w_bypass  = i_wr_en && (i_wr_addr == i_addr);

    // Storage is undefined until the clear sequence finishes, so reads are forced to 0.
    always_comb begin
        o_data = i_mem_data;
        if (!i_ready || w_is_zero) begin
            o_data = '0;
        end else if (w_bypass) begin
            o_data = i_wr_data;
        end
    end

endmodule

// File: rtl/reg_file.sv
// rtl/reg_file.sv - register file with post-reset sequential clear and two bypassed read ports
module reg_file #(
    parameter int WIDTH     = cpu_pkg::WIDTH,
    parameter int REG_COUNT = cpu_pkg::REG_COUNT,
    parameter int ADDR_W    = cpu_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              reg_write,
    output logic [WIDTH-1:0]  rs_data,
    output logic [WIDTH-1:0]  rt_data,
    output logic              ready
);

    import cpu_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(REG_COUNT - 1);

    logic [WIDTH-1:0]  r_mem [REG_COUNT];
    logic [0:0]        r_state;
    logic [ADDR_W-1:0] r_idx;
    logic              r_ready;

    logic              w_in_ready;
    logic              w_wr_en;

    assign w_in_ready = (r_state == ST_READY);
    assign w_wr_en    = w_in_ready && reg_write && (rd_addr != '0) && !reset;
    assign ready      = r_ready;

    // r0 is never stored-to and always reads 0, so the sweep starts at index 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_CLEAR;
            r_idx   <= ADDR_W'(1);
            r_ready <= 1'b0;
        end else if (r_state == ST_CLEAR) begin
            if (r_idx == LAST_IDX) begin
                r_state <= ST_READY;
                r_ready <= 1'b1;
            end else begin
                r_idx <= r_idx + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (r_state == ST_CLEAR) begin
                r_mem[r_idx] <= '0;
            end else if (w_wr_en) begin
                r_mem[rd_addr] <= wr_data;
            end
        end
    end

    reg_read_port #(
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W)
    ) u_port_rs (
        .i_addr     (rs_addr),
        .i_mem_data (r_mem[rs_addr]),
        .i_wr_addr  (rd_addr),
        .i_wr_data  (wr_data),
        .i_wr_en    (w_wr_en),
        .i_ready    (w_in_ready),
        .o_data     (rs_data)
    );

    reg_read_port #(
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W)
    ) u_port_rt (
        .i_addr     (rt_addr),
        .i_mem_data (r_mem[rt_addr]),
        .i_wr_addr  (rd_addr),
        .i_wr_data  (wr_data),
        .i_wr_en    (w_wr_en),
        .i_ready    (w_in_ready),
        .o_data     (rt_data)
    );

endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - scoreboard-driven self-checking bench for reg_file
module tb_reg_file;

    logic        clk;
    logic        reset;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [4:0]  rd_addr;
    logic [31:0] wr_data;
    logic        reg_write;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        ready;

    int          n_cmp;
    int          n_err;
    string       sb_tag [$];
    logic [31:0] sb_val [$];
    logic [31:0] mdl [32];

    reg_file dut (
        .clk       (clk),
        .reset     (reset),
        .rs_addr   (rs_addr),
        .rt_addr   (rt_addr),
        .rd_addr   (rd_addr),
        .wr_data   (wr_data),
        .reg_write (reg_write),
        .rs_data   (rs_data),
        .rt_data   (rt_data),
        .ready     (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input string tag, input logic [31:0] v);
        sb_tag.push_back(tag);
        sb_val.push_back(v);
    endtask

    task automatic pop_cmp(input logic [31:0] obs);
        string       t;
        logic [31:0] v;
        if (sb_val.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
        end else begin
            t = sb_tag.pop_front();
            v = sb_val.pop_front();
            check(t, obs, v);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        reg_write = 1'b1;
        rd_addr   = a;
        wr_data   = d;
        @(posedge clk);
        #1;
        reg_write = 1'b0;
        if (a != 5'd0) mdl[a] = d;
    endtask

    task automatic rd(input string tag, input logic [4:0] a, input logic [4:0] b);
        @(negedge clk);
        reg_write = 1'b0;
        rs_addr   = a;
        rt_addr   = b;
        push_exp({tag, "_rs"}, mdl[a]);
        push_exp({tag, "_rt"}, mdl[b]);
        #1;
        pop_cmp(rs_data);
        pop_cmp(rt_data);
    endtask

    // Counts edges after reset release; ready must rise only after edge 31.
    task automatic count_clear(input string tag);
        for (int e = 1; e <= 31; e++) begin
            @(posedge clk);
            #1;
            push_exp($sformatf("%s_ready_e%0d", tag, e), (e == 31) ? 32'd1 : 32'd0);
            pop_cmp({31'd0, ready});
            if (e == 5) begin
                push_exp({tag, "_clear_rs0"}, 32'h0);
                pop_cmp(rs_data);
            end
        end
        model_clear();
    endtask

    initial begin
        reset     = 1'b1;
        rs_addr   = 5'd5;
        rt_addr   = 5'd5;
        rd_addr   = 5'd0;
        wr_data   = 32'h0;
        reg_write = 1'b0;
        n_cmp     = 0;
        n_err     = 0;
        model_clear();

        repeat (2) @(posedge clk);
        #1;
        push_exp("rst_ready", 32'd0);
        pop_cmp({31'd0, ready});
        push_exp("rst_rs", 32'h0);
        pop_cmp(rs_data);
        @(negedge clk);
        reset = 1'b0;
        count_clear("init");
        for (int i = 0; i < 32; i++) rd($sformatf("clr_r%0d", i), 5'(i), 5'(31 - i));

        // Same-cycle bypass then readback from storage.
        @(negedge clk);
        reg_write = 1'b1;
        rd_addr   = 5'd5;
        wr_data   = 32'hDEADBEEF;
        rs_addr   = 5'd5;
        rt_addr   = 5'd5;
        push_exp("byp_rs", 32'hDEADBEEF);
        push_exp("byp_rt", 32'hDEADBEEF);
        #1;
        pop_cmp(rs_data);
        pop_cmp(rt_data);
        @(posedge clk);
        #1;
        reg_write = 1'b0;
        mdl[5]    = 32'hDEADBEEF;
        #1;
        push_exp("stor_r5", 32'hDEADBEEF);
        pop_cmp(rs_data);

        wr(5'd0, 32'h12345678);
        rd("r0", 5'd0, 5'd0);

        wr(5'd7, 32'hA5A5A5A5);
        wr(5'd8, 32'h0000000F);
        rd("alu_ab", 5'd7, 5'd8);

        for (int k = 0; k < 8; k++) wr(5'($urandom_range(0, 31)), $urandom);
        for (int i = 0; i < 32; i++) rd($sformatf("rnd_r%0d", i), 5'(i), 5'((i + 7) % 32));

        // Reset mid-clear with a write held on rd=4 throughout CLEAR.
        wr(5'd3, 32'h1);
        wr(5'd4, 32'h4);
        rd("pre_r3r4", 5'd3, 5'd4);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        reset     = 1'b1;
        reg_write = 1'b1;
        rd_addr   = 5'd4;
        wr_data   = 32'hCAFEF00D;
        rs_addr   = 5'd4;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        count_clear("abort");
        #1;
        reg_write = 1'b0;
        rd("post_r3r4", 5'd3, 5'd4);

        // Reset and write on the same edge: write is dropped.
        wr(5'd9, 32'h99);
        @(negedge clk);
        reset     = 1'b1;
        reg_write = 1'b1;
        rd_addr   = 5'd9;
        wr_data   = 32'hFF;
        @(posedge clk);
        @(negedge clk);
        reset     = 1'b0;
        reg_write = 1'b0;
        count_clear("rstwr");
        rd("r9", 5'd9, 5'd9);

        check("sb_drained", 32'(sb_val.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
